aes_cbc_ctrl: RTL and testbench
===============================

AES_CBC_CTRL -- requirements
Module: aes_cbc_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 127: maximum cycles waited for a core result before aborting.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cfg_start  in  1  one-cycle pulse; latch cfg_* and start key expansion.
REQ-005 cfg_key  in  256  key, left-aligned for 128/192-bit modes; cfg_key_mode  in  2  0:128, 1:192, 2:256; cfg_ende  in  1  0 encrypt, 1 decrypt; cfg_iv  in  128  CBC IV.
REQ-006 s_data  in  128, s_valid  in  1, s_last  in  1, s_ready  out  1: input block stream, valid/ready.
REQ-007 m_data  out  128, m_valid  out  1, m_last  out  1, m_ready  in  1: output block stream, valid/ready.
REQ-008 aes_start, aes_enable, aes_ende, aes_data_valid  out  1 each; aes_key  out  256; aes_key_mode  out  2; aes_data  out  128: drive the AES core.
REQ-009 aes_ready, aes_key_ready, aes_data_out_valid  in  1 each; aes_data_out  in  128: returned from the AES core.
REQ-010 busy  out  1 (state != IDLE); blk_cnt  out  16 (blocks delivered since last cfg_start); err_timeout, err_unexp  out  1 (sticky).

Function
REQ-011 FSM states are IDLE, KEY_WAIT, READY, ISSUE, WAIT_RES and OUT.
REQ-012 In IDLE or READY, cfg_start SHALL latch key, mode, ende and iv, load chain<=cfg_iv, clear blk_cnt and the error flags, pulse aes_start for one cycle, and go to KEY_WAIT; cfg_start in any other state is ignored.
REQ-013 In KEY_WAIT, aes_key_ready is ignored in the first cycle after the aes_start pulse; thereafter aes_key_ready=1 moves the FSM to READY.
REQ-014 s_ready SHALL equal (state==READY) & aes_ready & !cfg_start.
REQ-015 On s_valid&s_ready: encrypt registers aes_data<=s_data^chain; decrypt registers aes_data<=s_data and hold<=s_data; last_q<=s_last; next state is ISSUE.
REQ-016 In ISSUE, aes_data_valid=1 for exactly one cycle (the cycle after the accept); then the FSM goes to WAIT_RES and clears the timeout counter.
REQ-017 In WAIT_RES, on aes_data_out_valid: encrypt sets m_data<=aes_data_out and chain<=aes_data_out; decrypt sets m_data<=aes_data_out^chain and chain<=hold; m_last<=last_q; the FSM goes to OUT, with m_valid high in the following cycle.
REQ-018 In WAIT_RES, the 8-bit timeout counter increments every cycle; when it reaches TIMEOUT without a result, err_timeout<=1 and the FSM goes to IDLE.
REQ-019 In OUT, m_valid=1 and m_data/m_last are held stable until m_ready; on handshake blk_cnt increments (wrapping 0xFFFF->0), chain<=iv if m_last, and the FSM goes to READY.
REQ-020 aes_data_out_valid in any state other than WAIT_RES SHALL set err_unexp and is otherwise ignored.
REQ-021 aes_key, aes_key_mode and aes_ende are driven from the latched registers; aes_enable=1 in every cycle except reset.
REQ-022 At most one block is outstanding in the core.
REQ-023 Latency is s-accept -> aes_data_valid = 1 cycle and aes_data_out_valid -> m_valid = 1 cycle.

Reset
REQ-024 While reset is high, state<=IDLE and all outputs and registers are driven to 0, including aes_enable, s_ready, m_valid, busy, blk_cnt, err_*, chain, hold and aes_data.
REQ-025 A reset asserted mid-block abandons the block; no m_valid is issued for it afterwards.

Structure
REQ-026 A shared package aes_cbc_pkg SHALL hold the state enum, the key-mode constants (KEY128=0, KEY192=1, KEY256=2) and the TIMEOUT default.
REQ-027 The block is a single module with no sub-modules; the AES core is instantiated beside it at the top level.

Verification
REQ-028 Encrypt, SP800-38A: key 2b7e151628aed2a6abf7158809cf4f3c, mode 0, IV 000102..0f, P1 6bc1bee22e409f96e93d7e117393172a, P2 ae2d8a571e03ac9c9eb76fac45af8e51 (last) -> C1 7649abac8119b246cee98e9b12e9197d, C2 5086cb9b507219ee95db113a917678b2 with m_last on C2, and blk_cnt=2.
REQ-029 Decrypt with the same key/IV, input C1,C2 -> P1,P2 delivered in order.
REQ-030 Hold m_ready=0 for 10 cycles on C1 -> m_data stable, s_ready=0, and no new aes_data_valid.
REQ-031 Model core that never returns a result -> err_timeout=1 exactly TIMEOUT cycles after entering WAIT_RES, state IDLE, busy=0.
REQ-032 Inject aes_data_out_valid while in READY -> err_unexp=1 and no m_valid.
REQ-033 Assert reset during WAIT_RES, then re-run REQ-028 -> identical C1/C2 with no stale output.

Source files
------------

// File: rtl/aes_cbc_pkg.sv
// Shared types and constants for the AES-CBC chaining controller.
package aes_cbc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      KEY_WAIT,
      READY,
      ISSUE,
      WAIT_RES,
      OUT
   } state_t;

   localparam logic [1:0] KEY128 = 2'd0;
   localparam logic [1:0] KEY192 = 2'd1;
   localparam logic [1:0] KEY256 = 2'd2;

   localparam int TIMEOUT_DEFAULT = 127;

endpackage

// File: rtl/aes_cbc_ctrl.sv
// AES-CBC chaining controller: sequences key expansion on an external AES
// core, applies the CBC chaining XOR around each block and streams results.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no key loaded, or aborted after a core timeout
// KEY_WAIT | key expansion started, waiting for aes_key_ready
// READY    | key loaded, accepting the next input block
// ISSUE    | block presented to the core (aes_data_valid high)
// WAIT_RES | waiting for the core result, timeout counter running
// OUT      | result held on m_data until the consumer takes it
module aes_cbc_ctrl
   import aes_cbc_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cfg_start,
   input  logic [255:0] cfg_key,
   input  logic [1:0]   cfg_key_mode,
   input  logic         cfg_ende,
   input  logic [127:0] cfg_iv,
   input  logic [127:0] s_data,
   input  logic         s_valid,
   input  logic         s_last,
   output logic         s_ready,
   output logic [127:0] m_data,
   output logic         m_valid,
   output logic         m_last,
   input  logic         m_ready,
   output logic         aes_start,
   output logic         aes_enable,
   output logic         aes_ende,
   output logic         aes_data_valid,
   output logic [255:0] aes_key,
   output logic [1:0]   aes_key_mode,
   output logic [127:0] aes_data,
   input  logic         aes_ready,
   input  logic         aes_key_ready,
   input  logic         aes_data_out_valid,
   input  logic [127:0] aes_data_out,
   output logic         busy,
   output logic [15:0]  blk_cnt,
   output logic         err_timeout,
   output logic         err_unexp
);

   // counter value on the cycle whose edge completes TIMEOUT cycles in WAIT_RES
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t         state;
   logic [255:0]   key_q;
   logic [1:0]     mode_q;
   logic           ende_q;
   logic [127:0]   iv_q;
   logic [127:0]   chain;
   logic [127:0]   hold;
   logic           last_q;
   logic           kw_first;
   logic [7:0]     tmo_cnt;
   logic           accept;

   // cfg_start has priority over a block accept in the same cycle
   assign s_ready      = (state == READY) & aes_ready & ~cfg_start & ~reset;
   assign accept       = s_valid & s_ready;
   assign busy         = (state != IDLE);
   assign aes_key      = key_q;
   assign aes_key_mode = mode_q;
   assign aes_ende     = ende_q;

   // controller FSM with registered core/stream outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         key_q          <= '0;
         mode_q         <= '0;
         ende_q         <= 1'b0;
         iv_q           <= '0;
         chain          <= '0;
         hold           <= '0;
         last_q         <= 1'b0;
         kw_first       <= 1'b0;
         tmo_cnt        <= '0;
         aes_start      <= 1'b0;
         aes_enable     <= 1'b0;
         aes_data_valid <= 1'b0;
         aes_data       <= '0;
         m_data         <= '0;
         m_valid        <= 1'b0;
         m_last         <= 1'b0;
         blk_cnt        <= '0;
         err_timeout    <= 1'b0;
         err_unexp      <= 1'b0;
      end else begin
         aes_enable     <= 1'b1;
         aes_start      <= 1'b0;
         aes_data_valid <= 1'b0;
         case (state)
            IDLE, READY: begin
               if (cfg_start) begin
                  key_q       <= cfg_key;
                  mode_q      <= cfg_key_mode;
                  ende_q      <= cfg_ende;
                  iv_q        <= cfg_iv;
                  chain       <= cfg_iv;
                  blk_cnt     <= '0;
                  err_timeout <= 1'b0;
                  err_unexp   <= 1'b0;
                  aes_start   <= 1'b1;
                  kw_first    <= 1'b1;
                  state       <= KEY_WAIT;
               end else if (accept) begin
                  // decrypt keeps the ciphertext: it becomes the next chain value
                  aes_data       <= ende_q ? s_data : (s_data ^ chain);
                  if (ende_q) hold <= s_data;
                  last_q         <= s_last;
                  aes_data_valid <= 1'b1;
                  state          <= ISSUE;
               end
            end
            KEY_WAIT: begin
               // key_ready may still reflect the previous key while aes_start is high
               kw_first <= 1'b0;
               if (!kw_first && aes_key_ready) state <= READY;
            end
            ISSUE: begin
               tmo_cnt <= '0;
               state   <= WAIT_RES;
            end
            WAIT_RES: begin
               if (aes_data_out_valid) begin
                  m_data  <= ende_q ? (aes_data_out ^ chain) : aes_data_out;
                  chain   <= ende_q ? hold : aes_data_out;
                  m_last  <= last_q;
                  m_valid <= 1'b1;
                  state   <= OUT;
               end else if (tmo_cnt == TMO_LAST) begin
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  blk_cnt <= blk_cnt + 16'd1;
                  if (m_last) chain <= iv_q;
                  state   <= READY;
               end
            end
            default: state <= IDLE;
         endcase
         if (aes_data_out_valid && state != WAIT_RES) err_unexp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Directed bench for aes_cbc_ctrl with a lookup-table AES core model
// holding the SP800-38A CBC-AES128 known answers.
module tb_aes_cbc_ctrl;

   localparam int TMO = 127;

   logic         clk = 1'b0;
   logic         reset;
   logic         cfg_start;
   logic [255:0] cfg_key;
   logic [1:0]   cfg_key_mode;
   logic         cfg_ende;
   logic [127:0] cfg_iv;
   logic [127:0] s_data;
   logic         s_valid;
   logic         s_last;
   logic         s_ready;
   logic [127:0] m_data;
   logic         m_valid;
   logic         m_last;
   logic         m_ready;
   logic         aes_start;
   logic         aes_enable;
   logic         aes_ende;
   logic         aes_data_valid;
   logic [255:0] aes_key;
   logic [1:0]   aes_key_mode;
   logic [127:0] aes_data;
   logic         aes_ready;
   logic         aes_key_ready;
   logic         aes_data_out_valid;
   logic [127:0] aes_data_out;
   logic         busy;
   logic [15:0]  blk_cnt;
   logic         err_timeout;
   logic         err_unexp;

   int n_cmp = 0;
   int n_fail = 0;

   logic [127:0] KEY, IV, P1, P2, C1, C2, X1, X2;

   // core model controls
   logic         hang;
   logic         inj;
   logic [1:0]   dly;
   logic [1:0]   kcnt;

   always #5 clk = ~clk;

   aes_cbc_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_key_mode(cfg_key_mode),
      .cfg_ende(cfg_ende), .cfg_iv(cfg_iv),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .aes_start(aes_start), .aes_enable(aes_enable), .aes_ende(aes_ende),
      .aes_data_valid(aes_data_valid), .aes_key(aes_key), .aes_key_mode(aes_key_mode),
      .aes_data(aes_data), .aes_ready(aes_ready), .aes_key_ready(aes_key_ready),
      .aes_data_out_valid(aes_data_out_valid), .aes_data_out(aes_data_out),
      .busy(busy), .blk_cnt(blk_cnt), .err_timeout(err_timeout), .err_unexp(err_unexp)
   );

   // known-answer AES-128 single-block results; anything else returns garbage
   function automatic logic [127:0] core_lookup(input logic [127:0] d);
      logic [127:0] r;
      r = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
      if (aes_key == {KEY, 128'h0} && aes_key_mode == 2'd0) begin
         if (!aes_ende && d == X1) r = C1;
         if (!aes_ende && d == X2) r = C2;
         if (aes_ende && d == C1)  r = X1;
         if (aes_ende && d == C2)  r = X2;
      end
      return r;
   endfunction

   // AES core model: 3-cycle key expansion, 2-cycle block latency
   always @(posedge clk) begin
      if (reset) begin
         dly                <= 2'd0;
         kcnt               <= 2'd0;
         aes_key_ready      <= 1'b0;
         aes_data_out_valid <= 1'b0;
         aes_data_out       <= '0;
      end else begin
         if (aes_start) begin
            aes_key_ready <= 1'b0;
            kcnt          <= 2'd3;
         end else if (kcnt != 2'd0) begin
            kcnt <= kcnt - 2'd1;
            if (kcnt == 2'd1) aes_key_ready <= 1'b1;
         end
         if (aes_data_valid && !hang) begin
            dly          <= 2'd2;
            aes_data_out <= core_lookup(aes_data);
         end else if (dly != 2'd0) begin
            dly <= dly - 2'd1;
         end
         aes_data_out_valid <= (dly == 2'd1) | inj;
      end
   end

   task automatic do_config(input logic ende, output logic st1, output logic st2);
      @(negedge clk);
      cfg_key      = {KEY, 128'h0};
      cfg_key_mode = 2'd0;
      cfg_ende     = ende;
      cfg_iv       = IV;
      cfg_start    = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      st1 = aes_start;
      @(negedge clk);
      st2 = aes_start;
   endtask

   // returns just after the accepting edge (ISSUE cycle)
   task automatic send_block(input logic [127:0] d, input logic l, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      s_data  = d;
      s_last  = l;
      s_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic recv_block(output logic [127:0] d, output logic l, output bit ok);
      ok = 1'b0;
      d  = '0;
      l  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (m_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         d = m_data;
         l = m_last;
         m_ready = 1'b1;
         @(posedge clk);
         #1;
         m_ready = 1'b0;
      end
   endtask

   task automatic run_enc_pair(output logic [127:0] c1, output logic [127:0] c2,
                               output logic l1, output logic l2, output bit ok);
      logic s1, s2;
      bit   o1, o2, o3, o4;
      do_config(1'b0, s1, s2);
      send_block(P1, 1'b0, o1);
      recv_block(c1, l1, o2);
      send_block(P2, 1'b1, o3);
      recv_block(c2, l2, o4);
      ok = o1 & o2 & o3 & o4;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready got %b exp 0", s_ready); end
      n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_cmp++; if (aes_enable !== 1'b0) begin n_fail++; $display("FAIL rst_aes_enable got %b exp 0", aes_enable); end
      n_cmp++; if (blk_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_blk_cnt got %0d exp 0", blk_cnt); end
      n_cmp++; if ({err_timeout, err_unexp} !== 2'b00) begin n_fail++; $display("FAIL rst_err got %b exp 00", {err_timeout, err_unexp}); end
      n_cmp++; if (aes_data !== 128'h0) begin n_fail++; $display("FAIL rst_aes_data got %h exp 0", aes_data); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (aes_enable !== 1'b1) begin n_fail++; $display("FAIL run_aes_enable got %b exp 1", aes_enable); end
   endtask

   task automatic test_encrypt;
      logic         s1, s2, l1, l2;
      logic [127:0] c1, c2;
      bit           ok1, ok2, ok3, ok4;
      do_config(1'b0, s1, s2);
      n_cmp++; if ({s1, s2} !== 2'b10) begin n_fail++; $display("FAIL enc_aes_start_pulse got %b exp 10", {s1, s2}); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL enc_busy got %b exp 1", busy); end
      send_block(P1, 1'b0, ok1);
      n_cmp++; if (aes_data_valid !== 1'b1) begin n_fail++; $display("FAIL enc_issue_latency got %b exp 1", aes_data_valid); end
      n_cmp++; if (aes_data !== X1) begin n_fail++; $display("FAIL enc_aes_data got %h exp %h", aes_data, X1); end
      @(posedge clk); #1;
      n_cmp++; if (aes_data_valid !== 1'b0) begin n_fail++; $display("FAIL enc_issue_width got %b exp 0", aes_data_valid); end
      recv_block(c1, l1, ok2);
      send_block(P2, 1'b1, ok3);
      recv_block(c2, l2, ok4);
      n_cmp++; if ({ok1, ok2, ok3, ok4} !== 4'hf) begin n_fail++; $display("FAIL enc_handshakes got %b exp 1111", {ok1, ok2, ok3, ok4}); end
      n_cmp++; if (c1 !== C1) begin n_fail++; $display("FAIL enc_c1 got %h exp %h", c1, C1); end
      n_cmp++; if (l1 !== 1'b0) begin n_fail++; $display("FAIL enc_c1_last got %b exp 0", l1); end
      n_cmp++; if (c2 !== C2) begin n_fail++; $display("FAIL enc_c2 got %h exp %h", c2, C2); end
      n_cmp++; if (l2 !== 1'b1) begin n_fail++; $display("FAIL enc_c2_last got %b exp 1", l2); end
      n_cmp++; if (blk_cnt !== 16'd2) begin n_fail++; $display("FAIL enc_blk_cnt got %0d exp 2", blk_cnt); end
   endtask

   task automatic test_decrypt;
      logic         s1, s2, l1, l2;
      logic [127:0] p1, p2;
      bit           ok1, ok2, ok3, ok4;
      do_config(1'b1, s1, s2);
      n_cmp++; if (blk_cnt !== 16'd0) begin n_fail++; $display("FAIL dec_blk_cnt_clear got %0d exp 0", blk_cnt); end
      send_block(C1, 1'b0, ok1);
      n_cmp++; if (aes_data !== C1) begin n_fail++; $display("FAIL dec_aes_data got %h exp %h", aes_data, C1); end
      recv_block(p1, l1, ok2);
      send_block(C2, 1'b1, ok3);
      recv_block(p2, l2, ok4);
      n_cmp++; if ({ok1, ok2, ok3, ok4} !== 4'hf) begin n_fail++; $display("FAIL dec_handshakes got %b exp 1111", {ok1, ok2, ok3, ok4}); end
      n_cmp++; if (p1 !== P1) begin n_fail++; $display("FAIL dec_p1 got %h exp %h", p1, P1); end
      n_cmp++; if (p2 !== P2) begin n_fail++; $display("FAIL dec_p2 got %h exp %h", p2, P2); end
      n_cmp++; if ({l1, l2} !== 2'b01) begin n_fail++; $display("FAIL dec_last got %b exp 01", {l1, l2}); end
   endtask

   task automatic test_backpressure;
      logic         s1, s2, l1, l2;
      logic [127:0] c1, c2;
      bit           ok1, okv, ok3, ok4, ok5;
      int           bad_data, bad_rdy, bad_iss;
      bad_data = 0; bad_rdy = 0; bad_iss = 0; okv = 1'b0;
      do_config(1'b0, s1, s2);
      send_block(P1, 1'b0, ok1);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (m_valid) begin
            okv = 1'b1;
            break;
         end
      end
      s_data  = P2;
      s_last  = 1'b1;
      s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (m_data !== C1 || m_valid !== 1'b1) bad_data++;
         if (s_ready !== 1'b0) bad_rdy++;
         if (aes_data_valid !== 1'b0) bad_iss++;
      end
      s_valid = 1'b0;
      n_cmp++; if (okv !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid_seen got %b exp 1", okv); end
      n_cmp++; if (bad_data !== 0) begin n_fail++; $display("FAIL bp_m_data_stable got %0d bad cycles exp 0", bad_data); end
      n_cmp++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL bp_s_ready_low got %0d bad cycles exp 0", bad_rdy); end
      n_cmp++; if (bad_iss !== 0) begin n_fail++; $display("FAIL bp_no_issue got %0d bad cycles exp 0", bad_iss); end
      recv_block(c1, l1, ok3);
      send_block(P2, 1'b1, ok4);
      recv_block(c2, l2, ok5);
      n_cmp++; if ({ok1, ok3, ok4, ok5} !== 4'hf) begin n_fail++; $display("FAIL bp_handshakes got %b exp 1111", {ok1, ok3, ok4, ok5}); end
      n_cmp++; if (c1 !== C1 || c2 !== C2) begin n_fail++; $display("FAIL bp_data got %h %h exp %h %h", c1, c2, C1, C2); end
   endtask

   task automatic test_timeout;
      logic s1, s2;
      bit   ok1;
      hang = 1'b1;
      do_config(1'b0, s1, s2);
      send_block(P1, 1'b0, ok1);
      n_cmp++; if (ok1 !== 1'b1) begin n_fail++; $display("FAIL tmo_accept got %b exp 1", ok1); end
      // WAIT_RES is entered on the next edge; the abort lands TMO edges after that
      repeat (TMO) @(posedge clk);
      #1;
      n_cmp++; if ({err_timeout, busy} !== 2'b01) begin n_fail++; $display("FAIL tmo_early got err,busy=%b exp 01", {err_timeout, busy}); end
      @(posedge clk);
      #1;
      n_cmp++; if ({err_timeout, busy} !== 2'b10) begin n_fail++; $display("FAIL tmo_fire got err,busy=%b exp 10", {err_timeout, busy}); end
      n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL tmo_idle_s_ready got %b exp 0", s_ready); end
      hang = 1'b0;
   endtask

   task automatic test_unexpected;
      logic s1, s2;
      int   seen;
      seen = 0;
      do_config(1'b0, s1, s2);
      n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL unx_tmo_cleared got %b exp 0", err_timeout); end
      for (int i = 0; i < 60 && !s_ready; i++) @(negedge clk);
      n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL unx_ready got %b exp 1", s_ready); end
      inj = 1'b1;
      @(negedge clk);
      inj = 1'b0;
      @(negedge clk);
      n_cmp++; if (err_unexp !== 1'b1) begin n_fail++; $display("FAIL unx_err got %b exp 1", err_unexp); end
      for (int i = 0; i < 5; i++) begin
         if (m_valid !== 1'b0) seen++;
         @(negedge clk);
      end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL unx_no_m_valid got %0d cycles exp 0", seen); end
      n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL unx_still_ready got %b exp 1", s_ready); end
   endtask

   task automatic test_reset_mid;
      logic         s1, s2, l1, l2;
      logic [127:0] c1, c2;
      bit           ok1, ok2;
      int           seen;
      seen = 0;
      do_config(1'b0, s1, s2);
      send_block(P1, 1'b0, ok1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if ({busy, m_valid} !== 2'b00) begin n_fail++; $display("FAIL mid_rst got busy,m_valid=%b exp 00", {busy, m_valid}); end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_valid !== 1'b0) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_stale got %0d cycles exp 0", seen); end
      run_enc_pair(c1, c2, l1, l2, ok2);
      n_cmp++; if (ok2 !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_handshakes got %b exp 1", ok2); end
      n_cmp++; if (c1 !== C1 || c2 !== C2) begin n_fail++; $display("FAIL mid_rerun_data got %h %h exp %h %h", c1, c2, C1, C2); end
      n_cmp++; if ({l1, l2} !== 2'b01) begin n_fail++; $display("FAIL mid_rerun_last got %b exp 01", {l1, l2}); end
      n_cmp++; if (blk_cnt !== 16'd2) begin n_fail++; $display("FAIL mid_rerun_blk_cnt got %0d exp 2", blk_cnt); end
   endtask

   initial begin
      KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      IV  = 128'h000102030405060708090a0b0c0d0e0f;
      P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
      P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      C1  = 128'h7649abac8119b246cee98e9b12e9197d;
      C2  = 128'h5086cb9b507219ee95db113a917678b2;
      X1  = P1 ^ IV;
      X2  = P2 ^ C1;
      reset        = 1'b1;
      cfg_start    = 1'b0;
      cfg_key      = '0;
      cfg_key_mode = 2'd0;
      cfg_ende     = 1'b0;
      cfg_iv       = '0;
      s_data       = '0;
      s_valid      = 1'b0;
      s_last       = 1'b0;
      m_ready      = 1'b0;
      aes_ready    = 1'b1;
      hang         = 1'b0;
      inj          = 1'b0;

      test_reset;
      test_encrypt;
      test_decrypt;
      test_backpressure;
      test_timeout;
      test_unexpected;
      test_reset_mid;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
